// File: rtl/dbg_scan_pkg.sv
// Shared types and constants for the debug scan controller.
package dbg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  localparam int          ACK_TIMEOUT = 256;
  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;
  localparam int          REG_COUNT   = 32;

  // Register index sits in [4:0]; memory words are MEM_BASE + 4*index with 16-bit wrap.
  function automatic logic [15:0] scan_addr(input logic is_mem, input logic [7:0] idx,
                                            input logic [15:0] base);
    scan_addr = is_mem ? (base + {6'd0, idx, 2'b00}) : {11'd0, idx[4:0]};
  endfunction

endpackage

// File: rtl/dbg_dwell_timer.sv
// Dwell counter: clear has priority, counts while enabled, expire pulses on the last count.
module dbg_dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dbg_scan_ctrl.sv
// Debug scan controller: walks register file or data memory through the core debug port.
// Optional macro DBG_SCAN_REFRESH_EN re-reads the current entry while paused.
module dbg_scan_ctrl
  import dbg_scan_pkg::*;
#(
  parameter int          DWELL_CYCLES = 50_000_000,
  parameter int          MEM_WORDS    = 16,
  parameter logic [15:0] MEM_BASE     = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mode_i,
  input  logic        run_i,
  input  logic        step_i,
  output logic        rd_req_o,
  output logic        rd_is_mem_o,
  output logic [15:0] rd_addr_o,
  input  logic        rd_ack_i,
  input  logic [31:0] rd_data_i,
  output logic [15:0] disp_addr_o,
  output logic [31:0] disp_data_o,
  output logic        disp_valid_o,
  output logic        err_o
);

  localparam logic [7:0] MEM_LAST = 8'(MEM_WORDS - 1);
  localparam logic [7:0] REG_LAST = 8'(REG_COUNT - 1);
  localparam logic [7:0] TO_LAST  = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        req_mem_q, req_mem_d;
  logic        pend_q, pend_d;
  logic        mode_q, step_q;
  logic [15:0] disp_addr_q, disp_addr_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic        disp_valid_q, disp_valid_d;
  logic        err_q, err_d;

  logic       in_show, mode_chg, step_rise, timeout, dwell_clr, dwell_en, dwell_exp;
  logic [7:0] next_idx;

  assign in_show   = (state_q == ST_SHOW);
  assign mode_chg  = mode_i ^ mode_q;
  assign step_rise = step_i & ~step_q;
  assign timeout   = (state_q == ST_REQ) && !rd_ack_i && (to_cnt_q == TO_LAST);
  assign next_idx  = (idx_q == (mode_i ? MEM_LAST : REG_LAST)) ? 8'd0 : idx_q + 8'd1;

`ifdef DBG_SCAN_REFRESH_EN
  // Timer keeps running while paused so the shown entry is periodically re-read.
  logic run_q;
  assign dwell_en  = in_show;
  assign dwell_clr = !in_show || (run_i ^ run_q);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) run_q <= 1'b0;
    else        run_q <= run_i;
  end
`else
  assign dwell_en  = in_show && run_i;
  assign dwell_clr = !in_show || !run_i;
`endif

  dbg_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (dwell_clr),
    .en_i     (dwell_en),
    .expire_o (dwell_exp)
  );

  assign rd_req_o     = (state_q == ST_REQ);
  assign rd_is_mem_o  = req_mem_q;
  assign rd_addr_o    = scan_addr(req_mem_q, idx_q, MEM_BASE);
  assign disp_addr_o  = disp_addr_q;
  assign disp_data_o  = disp_data_q;
  assign disp_valid_o = disp_valid_q;
  assign err_o        = err_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    to_cnt_d     = '0;
    req_mem_d    = req_mem_q;
    pend_d       = 1'b0;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_REQ;
        req_mem_d = mode_i;
        if (mode_chg) idx_d = '0;
      end
      ST_REQ: begin
        to_cnt_d = to_cnt_q + 8'd1;
        pend_d   = pend_q | mode_chg;
        if (rd_ack_i || timeout) begin
          to_cnt_d = '0;
          pend_d   = 1'b0;
          // A mode switch during the handshake makes this result stale: drop it and restart.
          if (pend_q || mode_chg) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_SHOW;
            disp_addr_d  = rd_addr_o;
            disp_data_d  = rd_ack_i ? rd_data_i : ERR_PATTERN;
            disp_valid_d = 1'b1;
            err_d        = !rd_ack_i;
          end
        end
      end
      ST_SHOW: begin
        if (mode_chg) begin
          idx_d     = '0;
          state_d   = ST_REQ;
          req_mem_d = mode_i;
        end else if (step_rise || (run_i && dwell_exp)) begin
          idx_d     = next_idx;
          state_d   = ST_REQ;
          req_mem_d = mode_i;
        end
`ifdef DBG_SCAN_REFRESH_EN
        else if (dwell_exp) begin
          state_d   = ST_REQ;
          req_mem_d = mode_i;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      to_cnt_q     <= '0;
      req_mem_q    <= 1'b0;
      pend_q       <= 1'b0;
      mode_q       <= 1'b0;
      step_q       <= 1'b0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      to_cnt_q     <= to_cnt_d;
      req_mem_q    <= req_mem_d;
      pend_q       <= pend_d;
      mode_q       <= mode_i;
      step_q       <= step_i;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_dbg_scan_ctrl.sv
// Directed bench for dbg_scan_ctrl (DWELL_CYCLES=4, MEM_WORDS=4, MEM_BASE=0x0100).
module tb_dbg_scan_ctrl;

  localparam int ACK_LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mode_i = 1'b0, run_i = 1'b1, step_i = 1'b0;
  logic        rd_req_o, rd_is_mem_o, rd_ack_i;
  logic [15:0] rd_addr_o, disp_addr_o;
  logic [31:0] rd_data_i, disp_data_o;
  logic        disp_valid_o, err_o;

  logic        ack_gen = 1'b0, late_ack = 1'b0, ack_en = 1'b1;
  logic [31:0] data_gen = '0;
  int          checks = 0, errors = 0;

  assign rd_ack_i  = ack_gen | late_ack;
  assign rd_data_i = late_ack ? 32'h1234_5678 : data_gen;

  dbg_scan_ctrl #(.DWELL_CYCLES(4), .MEM_WORDS(4), .MEM_BASE(16'h0100)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .run_i(run_i), .step_i(step_i),
    .rd_req_o(rd_req_o), .rd_is_mem_o(rd_is_mem_o), .rd_addr_o(rd_addr_o),
    .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i), .disp_addr_o(disp_addr_o),
    .disp_data_o(disp_data_o), .disp_valid_o(disp_valid_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] model_data(input logic is_mem, input logic [15:0] a);
    model_data = is_mem ? (32'hC000_0000 | {16'd0, a}) : (32'h0000_00A0 + {27'd0, a[4:0]});
  endfunction

  // Core-side responder: acknowledges each request ACK_LAT samples after it appears.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk_i); #1;
      if (ack_gen) ack_gen = 1'b0;
      else if (rd_req_o && ack_en) begin
        if (wait_cnt == ACK_LAT - 1) begin
          ack_gen  = 1'b1;
          data_gen = model_data(rd_is_mem_o, rd_addr_o);
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  task automatic wait_req(input logic lvl, input int max, output int cyc);
    cyc = 0;
    while (rd_req_o !== lvl && cyc < max) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    if (rd_req_o !== lvl) begin
      checks++; errors++;
      $display("FAIL wait_req level %0d not reached after %0d cycles", lvl, cyc);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    #3 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (rd_req_o !== 1'b0)     begin errors++; $display("FAIL rst_req got %b want 0", rd_req_o); end
    checks++; if (rd_is_mem_o !== 1'b0)  begin errors++; $display("FAIL rst_is_mem got %b want 0", rd_is_mem_o); end
    checks++; if (rd_addr_o !== 16'h0)   begin errors++; $display("FAIL rst_addr got %h want 0", rd_addr_o); end
    checks++; if (disp_addr_o !== 16'h0) begin errors++; $display("FAIL rst_disp_addr got %h want 0", disp_addr_o); end
    checks++; if (disp_data_o !== 32'h0) begin errors++; $display("FAIL rst_disp_data got %h want 0", disp_data_o); end
    checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", disp_valid_o); end
    checks++; if (err_o !== 1'b0)        begin errors++; $display("FAIL rst_err got %b want 0", err_o); end
    @(negedge clk_i) rst_i = 1'b1;
    #1;
    checks++; if (rd_req_o !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", rd_req_o); end
    @(posedge clk_i); #1;
    checks++; if (rd_req_o !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", rd_req_o); end
  endtask

  task automatic test_reg_scan;
    int cyc;
    logic [15:0] ea;
    for (int i = 0; i < 34; i++) begin
      ea = 16'(i % 32);
      wait_req(1'b1, 20, cyc);
      if (i > 0) begin
        checks++; if (cyc != 4) begin errors++; $display("FAIL reg_dwell[%0d] got %0d want 4", i, cyc); end
      end
      checks++;
      if (rd_addr_o !== ea || rd_is_mem_o !== 1'b0) begin
        errors++; $display("FAIL reg_addr[%0d] got %h/%b want %h/0", i, rd_addr_o, rd_is_mem_o, ea);
      end
      wait_req(1'b0, 20, cyc);
      checks++;
      if (disp_data_o !== 32'hA0 + 32'(i % 32) || disp_addr_o !== ea || disp_valid_o !== 1'b1 || err_o !== 1'b0) begin
        errors++; $display("FAIL reg_disp[%0d] got %h@%h v%b e%b want %h@%h v1 e0", i, disp_data_o,
                           disp_addr_o, disp_valid_o, err_o, 32'hA0 + 32'(i % 32), ea);
      end
    end
  endtask

  task automatic test_mem_scan;
    int cyc;
    logic [15:0] ea;
    mode_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ea = 16'h0100 + 16'((i % 4) * 4);
      wait_req(1'b1, 20, cyc);
      checks++;
      if (rd_addr_o !== ea || rd_is_mem_o !== 1'b1) begin
        errors++; $display("FAIL mem_addr[%0d] got %h/%b want %h/1", i, rd_addr_o, rd_is_mem_o, ea);
      end
      wait_req(1'b0, 20, cyc);
      checks++;
      if (disp_data_o !== (32'hC000_0000 | {16'd0, ea}) || disp_addr_o !== ea) begin
        errors++; $display("FAIL mem_disp[%0d] got %h@%h want %h@%h", i, disp_data_o, disp_addr_o,
                           32'hC000_0000 | {16'd0, ea}, ea);
      end
    end
  endtask

  task automatic test_paused;
    int cyc, rises, bad;
    logic prev;
    run_i = 1'b0;
    rises = 0; bad = 0; prev = rd_req_o;
    repeat (100) begin
      @(posedge clk_i); #1;
      if (rd_req_o && !prev) begin
        rises++;
        if (rd_addr_o !== 16'h0100) bad++;
      end
      prev = rd_req_o;
    end
`ifdef DBG_SCAN_REFRESH_EN
    checks++; if (rises < 10 || bad != 0) begin errors++; $display("FAIL refresh got %0d reads %0d wrong addr want >=10 at 0100", rises, bad); end
`else
    checks++; if (rises != 0) begin errors++; $display("FAIL paused_idle got %0d reads want 0", rises); end
`endif
    wait_req(1'b0, 20, cyc);
    step_i = 1'b1;
    @(posedge clk_i); #1;
    step_i = 1'b0;
    checks++;
    if (rd_req_o !== 1'b1 || rd_addr_o !== 16'h0104) begin
      errors++; $display("FAIL step_req got %b@%h want 1@0104", rd_req_o, rd_addr_o);
    end
    step_i = 1'b1;
    @(posedge clk_i); #1;
    step_i = 1'b0;
    wait_req(1'b0, 20, cyc);
    checks++;
    if (disp_data_o !== 32'hC000_0104) begin errors++; $display("FAIL step_disp got %h want c0000104", disp_data_o); end
    rises = 0; bad = 0; prev = rd_req_o;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (rd_req_o && !prev) begin
        rises++;
        if (rd_addr_o !== 16'h0104) bad++;
      end
      prev = rd_req_o;
    end
`ifdef DBG_SCAN_REFRESH_EN
    checks++; if (bad != 0) begin errors++; $display("FAIL refresh_step got %0d wrong reads want 0", bad); end
`else
    checks++; if (rises != 0) begin errors++; $display("FAIL step_in_req got %0d extra reads want 0", rises); end
`endif
  endtask

  task automatic test_back_to_back;
    int cyc;
    run_i = 1'b1;
    wait_req(1'b0, 20, cyc);
    wait_req(1'b1, 20, cyc);
    checks++; if (rd_addr_o !== 16'h0108) begin errors++; $display("FAIL resume_addr got %h want 0108", rd_addr_o); end
    wait_req(1'b0, 20, cyc);
    repeat (3) @(posedge clk_i);
    #1;
    step_i = 1'b1;
    @(posedge clk_i); #1;
    step_i = 1'b0;
    checks++;
    if (rd_req_o !== 1'b1 || rd_addr_o !== 16'h010C) begin
      errors++; $display("FAIL dual_adv got %b@%h want 1@010c", rd_req_o, rd_addr_o);
    end
    wait_req(1'b0, 20, cyc);
    wait_req(1'b1, 20, cyc);
    checks++;
    if (cyc != 4 || rd_addr_o !== 16'h0100) begin
      errors++; $display("FAIL dual_next got %h after %0d want 0100 after 4", rd_addr_o, cyc);
    end
  endtask

  task automatic test_timeout;
    int cyc;
    wait_req(1'b0, 20, cyc);
    ack_en = 1'b0;
    wait_req(1'b1, 20, cyc);
    wait_req(1'b0, 300, cyc);
    checks++; if (cyc != 256) begin errors++; $display("FAIL timeout_len got %0d want 256", cyc); end
    checks++;
    if (disp_data_o !== 32'hDEAD_BEEF || err_o !== 1'b1 || disp_valid_o !== 1'b1 || disp_addr_o !== 16'h0104) begin
      errors++; $display("FAIL timeout_disp got %h@%h e%b v%b want deadbeef@0104 e1 v1", disp_data_o,
                         disp_addr_o, err_o, disp_valid_o);
    end
    ack_en = 1'b1;
    wait_req(1'b1, 20, cyc);
    checks++; if (rd_addr_o !== 16'h0108) begin errors++; $display("FAIL after_to_addr got %h want 0108", rd_addr_o); end
    wait_req(1'b0, 20, cyc);
    checks++;
    if (err_o !== 1'b0 || disp_data_o !== 32'hC000_0108) begin
      errors++; $display("FAIL err_clear got e%b %h want e0 c0000108", err_o, disp_data_o);
    end
  endtask

  task automatic test_mode_mid_req;
    int cyc;
    wait_req(1'b1, 20, cyc);
    checks++; if (rd_addr_o !== 16'h010C) begin errors++; $display("FAIL pre_mode_addr got %h want 010c", rd_addr_o); end
    mode_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (rd_req_o !== 1'b1 || rd_is_mem_o !== 1'b1 || rd_addr_o !== 16'h010C) begin
      errors++; $display("FAIL req_stable got %b/%b@%h want 1/1@010c", rd_req_o, rd_is_mem_o, rd_addr_o);
    end
    wait_req(1'b0, 10, cyc);
    checks++;
    if (disp_data_o !== 32'hC000_0108 || disp_addr_o !== 16'h0108) begin
      errors++; $display("FAIL stale_hidden got %h@%h want c0000108@0108", disp_data_o, disp_addr_o);
    end
    wait_req(1'b1, 10, cyc);
    checks++;
    if (cyc != 1 || rd_addr_o !== 16'h0000 || rd_is_mem_o !== 1'b0) begin
      errors++; $display("FAIL mode_restart got %h/%b after %0d want 0000/0 after 1", rd_addr_o, rd_is_mem_o, cyc);
    end
    wait_req(1'b0, 10, cyc);
    checks++;
    if (disp_data_o !== 32'h0000_00A0 || disp_addr_o !== 16'h0000 || err_o !== 1'b0) begin
      errors++; $display("FAIL mode_disp got %h@%h e%b want a0@0000 e0", disp_data_o, disp_addr_o, err_o);
    end
  endtask

  task automatic test_reset_mid_req;
    int cyc;
    wait_req(1'b1, 20, cyc);
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (rd_req_o !== 1'b0 || rd_is_mem_o !== 1'b0 || rd_addr_o !== 16'h0 || disp_addr_o !== 16'h0 ||
        disp_data_o !== 32'h0 || disp_valid_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL async_rst got req%b mem%b a%h da%h dd%h v%b e%b want all zero", rd_req_o,
                         rd_is_mem_o, rd_addr_o, disp_addr_o, disp_data_o, disp_valid_o, err_o);
    end
    ack_en = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i    = 1'b1;
    late_ack = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (rd_req_o !== 1'b1 || disp_valid_o !== 1'b0 || disp_data_o !== 32'h0) begin
      errors++; $display("FAIL late_ack got req%b v%b %h want req1 v0 0", rd_req_o, disp_valid_o, disp_data_o);
    end
    @(negedge clk_i);
    late_ack = 1'b0;
    ack_en   = 1'b1;
    wait_req(1'b0, 10, cyc);
    checks++;
    if (disp_data_o !== 32'h0000_00A0 || disp_valid_o !== 1'b1 || disp_addr_o !== 16'h0) begin
      errors++; $display("FAIL post_rst_read got %h@%h v%b want a0@0000 v1", disp_data_o, disp_addr_o, disp_valid_o);
    end
  endtask

  initial begin
    test_reset;
    test_reg_scan;
    test_mem_scan;
    test_paused;
    test_back_to_back;
    test_timeout;
    test_mode_mid_req;
    test_reset_mid_req;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
